regfile_read_arbiter: RTL and testbench

Round-robin arbiter that shares the single 64-entry x 32-bit register read port, a 6-bit-select 64:1 mux, among several requesters. Requesters include the decode read port, the debug/scan port and the exception unit. Each cycle the block grants at most one requester, drives the mux select from that requester's address, and registers the selected word. The word returns to the winning requester one cycle later. It sits between the register array's read mux and the pipeline-stage clients.

---
 rtl/regfile_read_arbiter_if.sv | 69 ++++++
 rtl/regfile_read_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_read_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_read_arbiter_if
//
// Purpose:
//    Bundles every signal that passes between the register-file read arbiter
//    and its surroundings: the requesters, the 64:1 read mux, and the
//    returning read data.
//
// Parameters:
//    NUM_REQ - number of requesters (2..8)
//    ADDR_W  - register index width (the mux has 2^ADDR_W inputs)
//    DATA_W  - data word width
//
// Signals:
//    req        - per-requester read request, level, held until granted
//    addr       - packed register indices, requester i at [i*ADDR_W +: ADDR_W]
//    stall      - suppresses any grant in the current cycle
//    gnt        - one-hot combinational grant
//    mux_select - select driven into the register read mux
//    mux_data   - read mux output, combinational from mux_select
//    rdata      - registered read data
//    rvalid     - one-hot owner of rdata, one cycle after gnt
//    rid        - index of the owner of rdata, meaningful when |rvalid
//
// Modports:
//    slave  - the arbiter's view
//    master - the environment's view (requesters plus read mux)
// ---------------------------------------------------------------------------
interface regfile_read_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32
);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] addr;
   logic                      stall;
   logic [NUM_REQ-1:0]        gnt;
   logic [ADDR_W-1:0]         mux_select;
   logic [DATA_W-1:0]         mux_data;
   logic [DATA_W-1:0]         rdata;
   logic [NUM_REQ-1:0]        rvalid;
   logic [2:0]                rid;

   modport slave (
      input  req,
      input  addr,
      input  stall,
      input  mux_data,
      output gnt,
      output mux_select,
      output rdata,
      output rvalid,
      output rid
   );

   modport master (
      output req,
      output addr,
      output stall,
      output mux_data,
      input  gnt,
      input  mux_select,
      input  rdata,
      input  rvalid,
      input  rid
   );

endinterface

// File: rtl/regfile_read_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_read_arbiter
//
// Purpose:
//    Shares the single read port of the 64 x 32 register array among several
//    requesters (decode read port, debug/scan port, exception unit, ...).
//    Each cycle at most one requester is granted; its address drives the
//    read mux select and the selected word is registered, returning to the
//    winner one cycle later together with a one-hot rvalid and its index.
//
// Configuration macro:
//    ARB_ROUND_ROBIN_EN - when defined, the scan start pointer advances past
//                         each winner (round-robin). When undefined, the
//                         pointer is tied to 0 and arbitration is fixed
//                         priority with requester 0 highest.
//
// Ports:
//    clock   - sole clock, rising edge
//    reset_n - asynchronous active-low reset
//    bus     - regfile_read_arbiter_if.slave (req/addr/stall in, gnt and
//              mux_select out, mux_data in, rdata/rvalid/rid out)
//
// The module parameters must match those of the connected interface.
// ---------------------------------------------------------------------------
module regfile_read_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   regfile_read_arbiter_if.slave   bus
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int SCAN_W = PTR_W + 1;

   logic [NUM_REQ-1:0] cand;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   winner;
   logic               found;
   logic [SCAN_W-1:0]  scan_idx;
   logic [NUM_REQ-1:0] gnt_c;
   logic [ADDR_W-1:0]  select_c;

   logic [DATA_W-1:0]  rdata_q;
   logic [NUM_REQ-1:0] rvalid_q;
   logic [2:0]         rid_q;

   // A stalled cycle removes every requester from the candidate set.
   assign cand = bus.req & ~{NUM_REQ{bus.stall}};

   // Scan upward from ptr with wrap-around; the first candidate found wins.
   // The index is one bit wider than ptr so ptr+k never overflows before
   // the explicit wrap, which also keeps it in range for non-power-of-two
   // requester counts.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, ptr} + SCAN_W'(k);
         if (scan_idx >= SCAN_W'(NUM_REQ)) begin
            scan_idx = scan_idx - SCAN_W'(NUM_REQ);
         end
         if (!found && cand[scan_idx[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = scan_idx[PTR_W-1:0];
         end
      end
   end

   // One-hot grant and the winner's address onto the mux select; both are
   // zero when nobody wins so the mux sits on entry 0 while idle.
   always_comb begin
      gnt_c    = '0;
      select_c = '0;
      if (found) begin
         gnt_c[winner] = 1'b1;
         select_c      = bus.addr[winner*ADDR_W +: ADDR_W];
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // The pointer moves just past the latest winner so that winner has the
   // lowest priority next cycle; idle and stalled cycles leave it alone.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (found) begin
         if (winner == PTR_W'(NUM_REQ - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= winner + 1'b1;
         end
      end
   end
`else
   // Fixed priority: the scan always starts at requester 0.
   assign ptr = '0;
`endif

   // Capture the mux output at the end of a grant cycle. Cycles without a
   // grant only drop rvalid, so the last word and owner stay visible. An
   // asynchronous reset between grant and capture discards the grant.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q  <= '0;
         rvalid_q <= '0;
         rid_q    <= '0;
      end else if (found) begin
         rdata_q  <= bus.mux_data;
         rvalid_q <= gnt_c;
         rid_q    <= 3'(winner);
      end else begin
         rvalid_q <= '0;
      end
   end

   assign bus.gnt        = gnt_c;
   assign bus.mux_select = select_c;
   assign bus.rdata      = rdata_q;
   assign bus.rvalid     = rvalid_q;
   assign bus.rid        = rid_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_read_arbiter
//
// Purpose:
//    Self-checking bench for regfile_read_arbiter with NUM_REQ=4. A register
//    array in the bench stands in for the read mux. A reference model keeps
//    a scan start index and the expected registered outputs, and follows
//    the ARB_ROUND_ROBIN_EN macro exactly as the design does.
// ---------------------------------------------------------------------------
module tb_regfile_read_arbiter;

   localparam int N  = 4;
   localparam int AW = 6;
   localparam int DW = 32;

   logic clock;
   logic reset_n;

   regfile_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   regfile_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Register array standing in for the read mux.
   logic [DW-1:0] regs [64];
   assign bus.mux_data = regs[bus.mux_select];

   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;

   // Stimulus state driven onto the bus.
   bit [N-1:0] m_req;
   int         m_addr [N];
   bit         m_stall;

   // Reference model state.
   int            mptr;
   logic [DW-1:0] exp_rdata;
   logic [N-1:0]  exp_rvalid;
   logic [2:0]    exp_rid;

   int lastw;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus();
      logic [N*AW-1:0] packed_addr;
      packed_addr = '0;
      for (int i = 0; i < N; i++) packed_addr[i*AW +: AW] = AW'(m_addr[i]);
      bus.req   = m_req;
      bus.addr  = packed_addr;
      bus.stall = m_stall;
   endtask

   // Winner by the arbitration rule: first requesting index in the order
   // ptr, ptr+1, ..., wrapping modulo N; -1 when stalled or nobody asks.
   function automatic int modelWinner();
      int w;
      w = -1;
      if (!m_stall) begin
         for (int k = 0; k < N; k++) begin
            if (w < 0 && m_req[(mptr + k) % N]) w = (mptr + k) % N;
         end
      end
      return w;
   endfunction

   task automatic modelReset();
      mptr       = 0;
      exp_rdata  = '0;
      exp_rvalid = '0;
      exp_rid    = '0;
   endtask

   // One clock cycle with inputs already applied: check the combinational
   // grant at the falling edge, then the registered result after the rise.
   task automatic runCycle(input string tag, output int w);
      logic [N-1:0] eg;
      int           esel;
      @(negedge clock);
      w    = modelWinner();
      eg   = '0;
      esel = 0;
      if (w >= 0) begin
         eg[w] = 1'b1;
         esel  = m_addr[w];
      end
      checkOutput({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
      checkOutput({tag, ".sel"}, 32'(bus.mux_select), 32'(esel));
      @(posedge clock);
      if (!reset_n) begin
         modelReset();
      end else if (w >= 0) begin
         exp_rdata  = regs[esel];
         exp_rvalid = eg;
         exp_rid    = 3'(w);
`ifdef ARB_ROUND_ROBIN_EN
         mptr = (w + 1) % N;
`endif
      end else begin
         exp_rvalid = '0;
      end
      #1;
      checkOutput({tag, ".rvalid"}, 32'(bus.rvalid), 32'(exp_rvalid));
      checkOutput({tag, ".rdata"},  bus.rdata, exp_rdata);
      checkOutput({tag, ".rid"},    32'(bus.rid), 32'(exp_rid));
   endtask

   initial begin
      logic [N-1:0] expseq;
      clock   = 1'b0;
      reset_n = 1'b0;
      m_req   = '0;
      m_stall = 1'b0;
      for (int i = 0; i < N; i++) m_addr[i] = 0;
      for (int i = 0; i < 64; i++) regs[i] = $urandom;
      regs[37] = 32'hDEAD0025;
      modelReset();
      applyStimulus();

      // Power-on reset state.
      #2;
      checkOutput("por.rvalid", 32'(bus.rvalid), 32'd0);
      checkOutput("por.rdata",  bus.rdata, 32'd0);
      checkOutput("por.rid",    32'(bus.rid), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Single read from requester 2 at register 37.
      m_req     = 4'b0100;
      m_addr[2] = 37;
      applyStimulus();
      runCycle("single", lastw);
      m_req = '0;
      applyStimulus();
      checkOutput("single.rdata_const",  bus.rdata, 32'hDEAD0025);
      checkOutput("single.rid_const",    32'(bus.rid), 32'd2);
      checkOutput("single.rvalid_const", 32'(bus.rvalid), 32'(4'b0100));

      // Reset mid-run with everyone requesting: outputs clear at once and
      // the grant still follows the (now zero) pointer.
      m_req = 4'b1111;
      for (int i = 0; i < N; i++) m_addr[i] = 10 + i;
      applyStimulus();
      runCycle("pre_rst", lastw);
      reset_n = 1'b0;
      #1;
      checkOutput("rst.rvalid_async", 32'(bus.rvalid), 32'd0);
      checkOutput("rst.rdata_async",  bus.rdata, 32'd0);
      modelReset();
      runCycle("rst_hold", lastw);
      reset_n = 1'b1;

      // Fairness: all four request continuously for 8 cycles.
      for (int k = 0; k < 8; k++) begin
         runCycle("rr", lastw);
`ifdef ARB_ROUND_ROBIN_EN
         expseq = 4'(1 << (k % 4));
`else
         expseq = 4'b0001;
`endif
         checkOutput("rr.rvalid_seq", 32'(bus.rvalid), 32'(expseq));
      end

      // Wrap-around: grant to 2 leaves the pointer at 3, then 1001.
      m_req = 4'b0100;
      applyStimulus();
      runCycle("wrap.setup", lastw);
      m_req = 4'b1001;
      applyStimulus();
      runCycle("wrap.first", lastw);
`ifdef ARB_ROUND_ROBIN_EN
      checkOutput("wrap.first_owner", 32'(bus.rvalid), 32'(4'b1000));
`else
      checkOutput("wrap.first_owner", 32'(bus.rvalid), 32'(4'b0001));
`endif
      if (lastw >= 0) m_req[lastw] = 1'b0;
      applyStimulus();
      runCycle("wrap.second", lastw);
`ifdef ARB_ROUND_ROBIN_EN
      checkOutput("wrap.second_owner", 32'(bus.rvalid), 32'(4'b0001));
`else
      checkOutput("wrap.second_owner", 32'(bus.rvalid), 32'(4'b1000));
`endif

      // Stall for three cycles, then release.
      m_req     = 4'b0010;
      m_addr[1] = 21;
      m_stall   = 1'b1;
      applyStimulus();
      for (int k = 0; k < 3; k++) runCycle("stall", lastw);
      checkOutput("stall.rvalid_low", 32'(bus.rvalid), 32'd0);
      m_stall = 1'b0;
      applyStimulus();
      runCycle("stall.release", lastw);
      checkOutput("stall.grant_owner", 32'(bus.rvalid), 32'(4'b0010));

      // Back-to-back reads by requester 1 alone: addr 5 then 63.
      m_req     = 4'b0010;
      m_addr[1] = 5;
      applyStimulus();
      runCycle("b2b.first", lastw);
      checkOutput("b2b.data5", bus.rdata, regs[5]);
      m_addr[1] = 63;
      applyStimulus();
      runCycle("b2b.second", lastw);
      checkOutput("b2b.data63", bus.rdata, regs[63]);

      // Reset asserted between grant and capture discards the grant.
      m_req     = 4'b0001;
      m_addr[0] = 7;
      applyStimulus();
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      modelReset();
      checkOutput("rst_mid.rvalid", 32'(bus.rvalid), 32'd0);
      checkOutput("rst_mid.rdata",  bus.rdata, 32'd0);
      reset_n = 1'b1;
      m_req   = '0;
      applyStimulus();
      runCycle("rst_mid.idle", lastw);

      // Randomized traffic obeying the hold-until-granted handshake.
      lastw = -1;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!m_req[i] || i == lastw) begin
               m_req[i]  = 1'($urandom_range(0, 1));
               m_addr[i] = int'($urandom_range(0, 63));
            end
         end
         m_stall = ($urandom_range(0, 4) == 0);
         applyStimulus();
         runCycle("rand", lastw);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
